// File: rtl/fu_issue_sched_pkg.sv
// Shared FU codes and LSU FSM encodings for the issue scheduler.
package fu_issue_sched_pkg;
  localparam int NUM_FU   = 3;
  localparam int LSU_LANE = 2;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'b00,
    FU_ALU1 = 2'b01,
    FU_LSU  = 2'b10,
    FU_NONE = 2'b11
  } fu_code_e;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_e;
endpackage

// File: rtl/fu_issue_sched_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 64
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = ptr + IW'(i);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/fu_issue_sched.sv
// Issue scheduler: per-FU round-robin select, ALU latency counters, LSU busy FSM.
// Optional per-FU grant/stall counters under FU_ISSUE_SCHED_STATS_EN.
module fu_issue_sched
  import fu_issue_sched_pkg::*;
#(
  parameter int N_ENTRIES   = 64,
  parameter int IDX_W       = 6,
  parameter int ALU_LAT     = 1,
  parameter int LSU_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_ENTRIES-1:0]     req_valid,
  input  logic [2*N_ENTRIES-1:0]   req_fu,
  input  logic                     lsu_done,
  input  logic                     flush,
  output logic [NUM_FU-1:0]        grant_valid,
  output logic [NUM_FU*IDX_W-1:0]  grant_idx,
  output logic [N_ENTRIES-1:0]     grant_vec,
  output logic [NUM_FU-1:0]        fu_free,
  output logic                     lsu_timeout
`ifdef FU_ISSUE_SCHED_STATS_EN
  ,
  output logic [NUM_FU*32-1:0]     stat_grants,
  output logic [NUM_FU*32-1:0]     stat_stalls
`endif
);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int TW = $clog2(LSU_TIMEOUT + 1);

  logic [N_ENTRIES-1:0][1:0]          fu_a;
  logic [NUM_FU-1:0][N_ENTRIES-1:0]   elig;
  logic [NUM_FU-1:0][IDX_W-1:0]       rr_ptr, win_idx, gidx_q;
  logic [NUM_FU-1:0]                  found, grant_go, gvalid_q;
  logic [N_ENTRIES-1:0]               gvec_nxt, gvec_q;
  logic [1:0][CW-1:0]                 alu_cnt;
  lsu_state_e                         lsu_state, lsu_state_nxt;
  logic [TW-1:0]                      lsu_timer, lsu_timer_nxt, lsu_timer_inc;
  logic                               lsu_to_fire, lsu_to_q;

  assign fu_a = req_fu;

  // Entries granted last cycle are masked until the RS has cleared their USE bit.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_FU; k++)
      for (int i = 0; i < N_ENTRIES; i++)
        elig[k][i] = req_valid[i] && (fu_a[i] == 2'(k)) && !gvec_q[i];
  end

  for (genvar k = 0; k < NUM_FU; k++) begin : g_arb
    rr_arbiter #(.N(N_ENTRIES)) u_arb (
      .req   (elig[k]),
      .ptr   (rr_ptr[k]),
      .idx   (win_idx[k]),
      .found (found[k])
    );
  end

  assign fu_free  = {lsu_state == LSU_IDLE, alu_cnt[1] == '0, alu_cnt[0] == '0};
  assign grant_go = fu_free & found & {NUM_FU{~flush}};

  always_comb begin
    gvec_nxt = '0;
    for (int k = 0; k < NUM_FU; k++)
      if (grant_go[k]) gvec_nxt[win_idx[k]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gvalid_q <= '0;
      gidx_q   <= '0;
      gvec_q   <= '0;
      rr_ptr   <= '0;
    end else begin
      gvalid_q <= grant_go;
      gvec_q   <= gvec_nxt;
      for (int k = 0; k < NUM_FU; k++)
        if (grant_go[k]) begin
          gidx_q[k] <= win_idx[k];
          rr_ptr[k] <= win_idx[k] + 1'b1;
        end
    end
  end

  // ALU occupancy: a grant loads ALU_LAT-1 remaining busy cycles.
  always_ff @(posedge clk) begin
    if (rst || flush) alu_cnt <= '0;
    else
      for (int a = 0; a < 2; a++) begin
        if (grant_go[a])          alu_cnt[a] <= CW'(ALU_LAT - 1);
        else if (alu_cnt[a] != '0) alu_cnt[a] <= alu_cnt[a] - 1'b1;
      end
  end

  assign lsu_timer_inc = lsu_timer + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_state <= LSU_IDLE;
      lsu_timer <= '0;
      lsu_to_q  <= 1'b0;
    end else begin
      lsu_state <= lsu_state_nxt;
      lsu_timer <= lsu_timer_nxt;
      lsu_to_q  <= lsu_to_q | lsu_to_fire;
    end
  end

  // Done wins over a coinciding timeout, so the sticky flag only marks true hangs.
  always_comb begin
    lsu_state_nxt = lsu_state;
    lsu_timer_nxt = lsu_timer;
    lsu_to_fire   = 1'b0;
    if (flush) begin
      lsu_state_nxt = LSU_IDLE;
      lsu_timer_nxt = '0;
    end else begin
      case (lsu_state)
        LSU_IDLE: if (grant_go[LSU_LANE]) begin
          lsu_state_nxt = LSU_BUSY;
          lsu_timer_nxt = '0;
        end
        LSU_BUSY: begin
          if (lsu_done) lsu_state_nxt = LSU_IDLE;
          else if (lsu_timer_inc == TW'(LSU_TIMEOUT)) begin
            lsu_state_nxt = LSU_IDLE;
            lsu_to_fire   = 1'b1;
          end else lsu_timer_nxt = lsu_timer_inc;
        end
        default: lsu_state_nxt = LSU_IDLE;
      endcase
    end
  end

  assign grant_valid = gvalid_q;
  assign grant_idx   = gidx_q;
  assign grant_vec   = gvec_q;
  assign lsu_timeout = lsu_to_q;

`ifdef FU_ISSUE_SCHED_STATS_EN
  logic [NUM_FU-1:0][31:0] grants_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else
      for (int k = 0; k < NUM_FU; k++) begin
        if (grant_go[k] && grants_q[k] != '1) grants_q[k] <= grants_q[k] + 32'd1;
        if ((|elig[k]) && !fu_free[k] && stalls_q[k] != '1) stalls_q[k] <= stalls_q[k] + 32'd1;
      end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_fu_issue_sched.sv
// Directed bench for fu_issue_sched: dut_a (ALU_LAT=1) and dut_b (ALU_LAT=3), both LSU_TIMEOUT=8.
module tb_fu_issue_sched;
  localparam int N  = 64;
  localparam int IW = 6;

  logic           clk = 1'b0;
  logic           rst, rst_b, lsu_done, flush;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_fu;
  logic [2:0]     a_gv, a_free, b_gv, b_free;
  logic [3*IW-1:0] a_gidx, b_gidx;
  logic [N-1:0]   a_gvec, b_gvec;
  logic           a_to, b_to;
`ifdef FU_ISSUE_SCHED_STATS_EN
  logic [95:0]    a_sg, a_ss, b_sg, b_ss;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fu_issue_sched #(.N_ENTRIES(N), .IDX_W(IW), .ALU_LAT(1), .LSU_TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_fu(req_fu), .lsu_done(lsu_done),
    .flush(flush), .grant_valid(a_gv), .grant_idx(a_gidx), .grant_vec(a_gvec),
    .fu_free(a_free), .lsu_timeout(a_to)
`ifdef FU_ISSUE_SCHED_STATS_EN
    , .stat_grants(a_sg), .stat_stalls(a_ss)
`endif
  );

  fu_issue_sched #(.N_ENTRIES(N), .IDX_W(IW), .ALU_LAT(3), .LSU_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_fu(req_fu), .lsu_done(lsu_done),
    .flush(flush), .grant_valid(b_gv), .grant_idx(b_gidx), .grant_vec(b_gvec),
    .fu_free(b_free), .lsu_timeout(b_to)
`ifdef FU_ISSUE_SCHED_STATS_EN
    , .stat_grants(b_sg), .stat_stalls(b_ss)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] fu);
    req_valid[i]      = 1'b1;
    req_fu[2*i +: 2]  = fu;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_b = 1'b1; flush = 1'b0; lsu_done = 1'b0;
    req_valid = '0; req_fu = '1;
    tick; tick;
    total++; if ({a_free, a_gv, a_to} !== 7'b111_000_0) begin
      bad++; $display("FAIL reset_a got free=%b gv=%b to=%b want 111/000/0", a_free, a_gv, a_to); end
    total++; if (a_gvec !== '0 || a_gidx !== '0) begin
      bad++; $display("FAIL reset_a_vec got gvec=%h gidx=%h want 0", a_gvec, a_gidx); end
    total++; if ({b_free, b_gv, b_to} !== 7'b111_000_0) begin
      bad++; $display("FAIL reset_b got free=%b gv=%b to=%b want 111/000/0", b_free, b_gv, b_to); end
    rst = 1'b0; rst_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      total++; if ({a_free, a_gv, a_to} !== 7'b111_000_0) begin
        bad++; $display("FAIL idle%0d got free=%b gv=%b to=%b want 111/000/0", c, a_free, a_gv, a_to); end
    end
  endtask

  task automatic test_fu_none;
    set_req(0, 2'b11); set_req(63, 2'b11);
    tick; tick;
    total++; if (a_gv !== 3'b000 || a_gvec !== '0) begin
      bad++; $display("FAIL fu_none got gv=%b gvec=%h want 000/0", a_gv, a_gvec); end
    req_valid = '0; req_fu = '1;
  endtask

  task automatic test_alu_rr;
    int exp_idx[4] = '{3, 10, 60, 3};
    logic [N-1:0] one;
    set_req(3, 2'b00); set_req(10, 2'b00); set_req(60, 2'b00);
    for (int c = 0; c < 4; c++) begin
      tick;
      one = '0; one[exp_idx[c]] = 1'b1;
      total++; if (a_gv !== 3'b001 || a_gidx[IW-1:0] !== IW'(exp_idx[c])) begin
        bad++; $display("FAIL rr%0d got gv=%b idx=%0d want 001/%0d", c, a_gv, a_gidx[IW-1:0], exp_idx[c]); end
      total++; if (a_gvec !== one) begin
        bad++; $display("FAIL rr_vec%0d got %h want %h", c, a_gvec, one); end
    end
    req_valid = '0;
    tick;
    total++; if (a_gv !== 3'b000) begin
      bad++; $display("FAIL rr_drain got gv=%b want 000", a_gv); end
  endtask

  task automatic test_parallel_lsu_done;
    req_fu = '1;
    set_req(5, 2'b00); set_req(6, 2'b01); set_req(7, 2'b10);
    tick;
    total++; if (a_gv !== 3'b111 || a_gidx !== {6'd7, 6'd6, 6'd5}) begin
      bad++; $display("FAIL par got gv=%b gidx=%h want 111/%h", a_gv, a_gidx, {6'd7, 6'd6, 6'd5}); end
    total++; if (a_gvec !== 64'hE0 || a_free !== 3'b011) begin
      bad++; $display("FAIL par_vec got gvec=%h free=%b want e0/011", a_gvec, a_free); end
    req_valid = '0; set_req(9, 2'b10);
    for (int c = 0; c < 3; c++) begin
      tick;
      total++; if (a_gv !== 3'b000 || a_free !== 3'b011) begin
        bad++; $display("FAIL lsu_busy%0d got gv=%b free=%b want 000/011", c, a_gv, a_free); end
    end
    lsu_done = 1'b1;
    tick;
    lsu_done = 1'b0;
    total++; if (a_free !== 3'b111 || a_gv !== 3'b000) begin
      bad++; $display("FAIL lsu_release got free=%b gv=%b want 111/000", a_free, a_gv); end
    tick;
    total++; if (a_gv !== 3'b100 || a_gidx[3*IW-1:2*IW] !== 6'd9 || a_free !== 3'b011) begin
      bad++; $display("FAIL lsu_regrant got gv=%b idx=%0d free=%b want 100/9/011", a_gv, a_gidx[3*IW-1:2*IW], a_free); end
    req_valid = '0;
  endtask

  task automatic test_lsu_timeout;
    for (int j = 1; j < 8; j++) begin
      tick;
      total++; if (a_free[2] !== 1'b0 || a_to !== 1'b0) begin
        bad++; $display("FAIL to_busy%0d got free2=%b to=%b want 0/0", j, a_free[2], a_to); end
    end
    tick;
    total++; if (a_free !== 3'b111 || a_to !== 1'b1) begin
      bad++; $display("FAIL to_fire got free=%b to=%b want 111/1", a_free, a_to); end
    lsu_done = 1'b1;
    tick;
    lsu_done = 1'b0;
    total++; if (a_free !== 3'b111 || a_gv !== 3'b000 || a_to !== 1'b1) begin
      bad++; $display("FAIL done_idle got free=%b gv=%b to=%b want 111/000/1", a_free, a_gv, a_to); end
    tick;
    total++; if (a_to !== 1'b1) begin
      bad++; $display("FAIL to_sticky got %b want 1", a_to); end
  endtask

  task automatic test_flush;
    rst_b = 1'b1;
    tick;
    rst_b = 1'b0;
    req_valid = '0; req_fu = '1;
    set_req(2, 2'b00); set_req(4, 2'b10);
    tick;
    total++; if (b_gv !== 3'b101 || b_gidx[IW-1:0] !== 6'd2 || b_gidx[3*IW-1:2*IW] !== 6'd4) begin
      bad++; $display("FAIL fl_grant got gv=%b gidx=%h want 101 idx0=2 idx2=4", b_gv, b_gidx); end
    total++; if (b_free !== 3'b010) begin
      bad++; $display("FAIL fl_busy got free=%b want 010", b_free); end
    flush = 1'b1;
    req_valid = '0; set_req(12, 2'b01);
    tick;
    flush = 1'b0;
    total++; if (b_gv !== 3'b000 || b_gvec !== '0 || b_free !== 3'b111) begin
      bad++; $display("FAIL fl_clear got gv=%b gvec=%h free=%b want 000/0/111", b_gv, b_gvec, b_free); end
    total++; if (a_to !== 1'b1 || a_free !== 3'b111) begin
      bad++; $display("FAIL fl_keep_to got to=%b free=%b want 1/111", a_to, a_free); end
`ifdef FU_ISSUE_SCHED_STATS_EN
    total++; if (b_sg !== {32'd1, 32'd0, 32'd1} || b_ss !== '0) begin
      bad++; $display("FAIL fl_stats got sg=%h ss=%h want %h/0", b_sg, b_ss, {32'd1, 32'd0, 32'd1}); end
`endif
    tick;
    total++; if (b_gv !== 3'b010 || b_gidx[2*IW-1:IW] !== 6'd12) begin
      bad++; $display("FAIL fl_after got gv=%b idx1=%0d want 010/12", b_gv, b_gidx[2*IW-1:IW]); end
    req_valid = '0;
    tick;
  endtask

  task automatic test_done_at_timeout;
    rst = 1'b1; rst_b = 1'b1;
    tick;
    rst = 1'b0; rst_b = 1'b0;
    total++; if (a_to !== 1'b0) begin
      bad++; $display("FAIL rst_to got %b want 0", a_to); end
    req_valid = '0; req_fu = '1;
    set_req(9, 2'b10);
    tick;
    total++; if (a_gv !== 3'b100) begin
      bad++; $display("FAIL dt_grant got gv=%b want 100", a_gv); end
    req_valid = '0;
    for (int j = 0; j < 7; j++) tick;
    total++; if (a_free[2] !== 1'b0) begin
      bad++; $display("FAIL dt_busy got free2=%b want 0", a_free[2]); end
    lsu_done = 1'b1;
    tick;
    lsu_done = 1'b0;
    total++; if (a_free !== 3'b111 || a_to !== 1'b0) begin
      bad++; $display("FAIL dt_done got free=%b to=%b want 111/0", a_free, a_to); end
  endtask

  initial begin
    test_reset;
    test_fu_none;
    test_alu_rr;
    test_parallel_lsu_done;
    test_lsu_timeout;
    test_flush;
    test_done_at_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
